di_sdram_port_ctrl: RTL
=======================

Name: di_sdram_port_ctrl

Overview:
Sequences one Spartan-6 MCB user port (UG388 cmd/wr/rd FIFOs) as a host-addressable terminal on the 16-bit di_* transfer bus. Packs host halfwords into 32-bit MCB words and issues bursted write commands. For reads, it issues bursted read commands and unpacks the returned words to the host. Instantiated in the top level alongside the FPGA terminal; the top-level mux selects its di_* outputs when di_term_addr == TERM_ADDR.

Parameters:
TERM_ADDR, 16'h0010, terminal address that owns this port
BURST, 16, max 32-bit words per MCB command (1..64)

Ports:
ifclk  input  1  48 MHz clock; also drives MCB port clock externally
resetb  input  1  reset, synchronous, active-low
di_term_addr  input  16  selected terminal
di_reg_addr  input  32  start byte address
di_len  input  32  transfer length in bytes
di_read_mode  input  1  host read transfer active
di_read  input  1  host consumes di_reg_datao this cycle
di_write_mode  input  1  host write transfer active
di_write  input  1  di_reg_datai valid this cycle
di_reg_datai  input  16  write halfword
di_read_rdy  output  1  di_reg_datao valid
di_reg_datao  output  16  read halfword
di_write_rdy  output  1  block accepts di_write
di_transfer_status  output  16  0 = ok, 16'h0001 = MCB error seen
p_cmd_en  output  1  command strobe
p_cmd_instr  output  3  000 write, 001 read
p_cmd_bl  output  6  burst length minus 1
p_cmd_byte_addr  output  30  command byte address, bits[1:0]=0
p_cmd_full  input  1  command FIFO full
p_wr_en  output  1  write FIFO push
p_wr_mask  output  4  byte mask, 1 = not written
p_wr_data  output  32  {second halfword, first halfword}
p_wr_full  input  1  write FIFO full
p_wr_underrun  input  1  MCB underrun
p_wr_error  input  1  MCB write error
p_rd_en  output  1  read FIFO pop
p_rd_data  input  32  read FIFO head
p_rd_empty  input  1  read FIFO empty
p_rd_overflow  input  1  MCB read overflow
p_rd_error  input  1  MCB read error

Behaviour:
- Reset (resetb low at ifclk edge): state IDLE; all counters, address and flags 0. All outputs 0. Outstanding MCB data is not flushed.
- sel = (di_term_addr == TERM_ADDR). Transfers start only on the rising edge of di_write_mode or di_read_mode (registered) while sel is high.
- On start: addr <= {di_reg_addr[31:2], 2'b00}. words <= di_len[31:2] + di_len[1]. tail <= di_len[1]. di_len[0] is ignored. Status flag is cleared.
- If words == 0 at start: return to IDLE and issue no commands.
- States: IDLE, WR_FILL, WR_CMD, WR_FLUSH, RD_CMD, RD_DRAIN, RD_FLUSH.
- WR_FILL:
  - di_write_rdy = sel && !p_wr_full && burst_cnt < BURST.
  - On an accepted even halfword, latch it as the low half.
  - On an accepted odd halfword, push {datai, low} in the same cycle with mask 0000; burst_cnt++, words--.
  - If tail is set and this is the last word, push after the low half with mask 1100.
  - When burst_cnt == BURST or words reaches 0, go to WR_CMD.
- WR_CMD:
  - Hold p_cmd_en until a cycle with !p_cmd_full; the command fires on that cycle.
  - On the fire cycle: instr 000, bl = burst_cnt-1, addr += 4*burst_cnt, burst_cnt <= 0.
  - Next state is IDLE if words == 0, else WR_FILL.
  - di_write_rdy is 0 while in this state.
- If di_write_mode falls mid-WR_FILL, go to WR_FLUSH:
  - Push any pending low half with mask 1100.
  - Then issue a command for burst_cnt words if burst_cnt > 0; then IDLE.
- RD_CMD:
  - n = min(BURST, words). Fire cmd instr 001, bl = n-1 under the same p_cmd_full rule as writes.
  - On fire: out_cnt <= n, addr += 4n, words -= n; go to RD_DRAIN.
- RD_DRAIN:
  - di_read_rdy = sel && !p_rd_empty.
  - di_reg_datao = half ? p_rd_data[31:16] : p_rd_data[15:0].
  - On di_read with rdy: if half == 0 and not (last word with tail), set half <= 1.
  - Otherwise pop: p_rd_en is combinational in that cycle, half <= 0, out_cnt--.
  - When out_cnt reaches 0: go to RD_CMD if words > 0, else IDLE.
  - di_read when not rdy is ignored.
- If di_read_mode falls while out_cnt > 0, go to RD_FLUSH:
  - Pop one word per cycle while !p_rd_empty until out_cnt == 0; then IDLE.
  - Host outputs are 0 during flush.
- di_transfer_status:
  - Becomes 16'h0001 (sticky) if any of p_wr_error, p_wr_underrun, p_rd_error or p_rd_overflow is sampled high after start.
  - Otherwise 0.
  - Cleared only at the next start.
- Write and read mode both high at start: write has priority; the read is ignored until the next rising edge.

Test Plan:
- Write: len=8, addr=0x100, halfwords 1,2,3,4 -> p_wr_data 0x00020001, then 0x00040003 (mask 0). One cmd: instr 000, bl=1, addr=0x100.
- Write: len=70, BURST=16, addr=0 -> cmd bl=15 at 0x0, then bl=1 at 0x40. Final word has mask 1100. Exactly 18 wr_en pulses.
- Read: len=12, p_rd_data words 0xBBBBAAAA, 0xDDDDCCCC, 0xFFFFEEEE -> cmd 001, bl=2. datao sequence AAAA, BBBB, CCCC, DDDD, EEEE, FFFF. Three rd_en pulses.
- p_cmd_full held high 10 cycles in WR_CMD -> p_cmd_en held, fires once on release. di_write_rdy stays 0 throughout.
- Read len=64: drop di_read_mode after 3 halfwords -> RD_FLUSH pops the remaining 15 words, then IDLE. A new read then works.
- Pulse p_rd_error for 1 cycle mid-read -> status 0x0001 until the next start, then 0. Reset mid-write -> all outputs 0 and state IDLE next cycle.

Source files
------------

// File: rtl/di_sdram_port_ctrl.sv
// di_sdram_port_ctrl
// Bridges the 16-bit di_* host transfer bus onto one Spartan-6 MCB user port.
// Host halfwords are packed into 32-bit MCB words (first halfword in the low
// half) and written with bursted write commands. Reads issue bursted read
// commands and return each word to the host low half first.
//
// Handshakes (all single-cycle, sampled at the rising edge of ifclk):
//   host write  : taken on a cycle with di_write && di_write_rdy
//   host read   : taken on a cycle with di_read && di_read_rdy
//   MCB command : fires on a cycle with p_cmd_en && !p_cmd_full
//   MCB wr push : p_wr_en is only raised while !p_wr_full
//   MCB rd pop  : p_rd_en is only raised while !p_rd_empty
// dbg_state_o exposes the FSM state for observation.
module di_sdram_port_ctrl #(
    parameter logic [15:0] TERM_ADDR = 16'h0010,
    parameter int unsigned BURST     = 16
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic [15:0] di_term_addr,
    input  logic [31:0] di_reg_addr,
    input  logic [31:0] di_len,
    input  logic        di_read_mode,
    input  logic        di_read,
    input  logic        di_write_mode,
    input  logic        di_write,
    input  logic [15:0] di_reg_datai,
    output logic        di_read_rdy,
    output logic [15:0] di_reg_datao,
    output logic        di_write_rdy,
    output logic [15:0] di_transfer_status,
    output logic        p_cmd_en,
    output logic [2:0]  p_cmd_instr,
    output logic [5:0]  p_cmd_bl,
    output logic [29:0] p_cmd_byte_addr,
    input  logic        p_cmd_full,
    output logic        p_wr_en,
    output logic [3:0]  p_wr_mask,
    output logic [31:0] p_wr_data,
    input  logic        p_wr_full,
    input  logic        p_wr_underrun,
    input  logic        p_wr_error,
    output logic        p_rd_en,
    input  logic [31:0] p_rd_data,
    input  logic        p_rd_empty,
    input  logic        p_rd_overflow,
    input  logic        p_rd_error,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_FILL  = 3'd1,
        WR_CMD   = 3'd2,
        WR_FLUSH = 3'd3,
        RD_CMD   = 3'd4,
        RD_DRAIN = 3'd5,
        RD_FLUSH = 3'd6
    } state_t;

    localparam logic [6:0] BURST_C = 7'(BURST);

    state_t      state_q,   state_d;
    logic [29:0] addr_q,    addr_d;
    logic [30:0] words_q,   words_d;
    logic        tail_q,    tail_d;
    logic [6:0]  burst_q,   burst_d;
    logic [15:0] low_q,     low_d;
    logic        low_vld_q, low_vld_d;
    logic        flush_q,   flush_d;
    logic [6:0]  out_cnt_q, out_cnt_d;
    logic        half_q,    half_d;
    logic        status_q,  status_d;
    logic        armed_q,   armed_d;
    logic        wmode_q;
    logic        rmode_q;

    logic        sel;
    logic        start_wr;
    logic        start_rd;
    logic [30:0] len_words;
    logic        mcb_err;
    logic        wr_rdy;
    logic        rd_rdy;
    logic        cmd_en;
    logic        cmd_fire;
    logic [6:0]  rd_n;
    logic [6:0]  burst_m1;
    logic [6:0]  rd_n_m1;
    logic        rd_last_tail;
    logic        wr_push;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        rd_pop;
    logic        unused_bits;

    assign sel          = (di_term_addr == TERM_ADDR);
    // Transfers start on a rising mode edge; write wins a simultaneous edge.
    assign start_wr     = sel && di_write_mode && !wmode_q;
    assign start_rd     = sel && di_read_mode && !rmode_q && !start_wr;
    // A trailing odd halfword (di_len[1]) still occupies one MCB word.
    assign len_words    = {1'b0, di_len[31:2]} + {30'd0, di_len[1]};
    assign mcb_err      = p_wr_error | p_wr_underrun | p_rd_error | p_rd_overflow;
    assign wr_rdy       = (state_q == WR_FILL) && sel && !p_wr_full && (burst_q < BURST_C);
    assign rd_rdy       = (state_q == RD_DRAIN) && sel && !p_rd_empty;
    // A read command is withdrawn if the host abandons the transfer first.
    assign cmd_en       = (state_q == WR_CMD) || ((state_q == RD_CMD) && di_read_mode);
    assign cmd_fire     = cmd_en && !p_cmd_full;
    assign rd_n         = (words_q < 31'(BURST)) ? words_q[6:0] : BURST_C;
    assign burst_m1     = burst_q - 7'd1;
    assign rd_n_m1      = rd_n - 7'd1;
    // The final word of a tail read only carries its low halfword.
    assign rd_last_tail = tail_q && (words_q == 31'd0) && (out_cnt_q == 7'd1);
    assign unused_bits  = ^{di_reg_addr[31:30], di_reg_addr[1:0], di_len[0],
                            burst_m1[6], rd_n_m1[6]};

    // Next-state and datapath decisions for the transfer sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        words_d   = words_q;
        tail_d    = tail_q;
        burst_d   = burst_q;
        low_d     = low_q;
        low_vld_d = low_vld_q;
        flush_d   = flush_q;
        out_cnt_d = out_cnt_q;
        half_d    = half_q;
        status_d  = status_q;
        armed_d   = armed_q;
        wr_push   = 1'b0;
        wr_mask   = 4'b0000;
        wr_data   = 32'h0;
        rd_pop    = 1'b0;

        if (armed_q && mcb_err) status_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_wr || start_rd) begin
                    addr_d    = {di_reg_addr[29:2], 2'b00};
                    words_d   = len_words;
                    tail_d    = di_len[1];
                    status_d  = 1'b0;
                    armed_d   = 1'b1;
                    burst_d   = 7'd0;
                    low_vld_d = 1'b0;
                    flush_d   = 1'b0;
                    half_d    = 1'b0;
                    out_cnt_d = 7'd0;
                    if (len_words == 31'd0) state_d = IDLE;
                    else if (start_wr)      state_d = WR_FILL;
                    else                    state_d = RD_CMD;
                end
            end
            WR_FILL: begin
                if (wr_rdy && di_write) begin
                    if (low_vld_q) begin
                        wr_push   = 1'b1;
                        wr_data   = {di_reg_datai, low_q};
                        low_vld_d = 1'b0;
                        burst_d   = burst_q + 7'd1;
                        words_d   = words_q - 31'd1;
                    end else if (tail_q && (words_q == 31'd1)) begin
                        wr_push   = 1'b1;
                        wr_mask   = 4'b1100;
                        wr_data   = {16'h0000, di_reg_datai};
                        burst_d   = burst_q + 7'd1;
                        words_d   = words_q - 31'd1;
                    end else begin
                        low_d     = di_reg_datai;
                        low_vld_d = 1'b1;
                    end
                end
                if (!di_write_mode)
                    state_d = WR_FLUSH;
                else if ((burst_d == BURST_C) || (words_d == 31'd0))
                    state_d = WR_CMD;
            end
            WR_FLUSH: begin
                if (low_vld_q) begin
                    if (!p_wr_full) begin
                        wr_push   = 1'b1;
                        wr_mask   = 4'b1100;
                        wr_data   = {16'h0000, low_q};
                        low_vld_d = 1'b0;
                        burst_d   = burst_q + 7'd1;
                        words_d   = words_q - 31'd1;
                    end
                end else if (burst_q == 7'd0) begin
                    state_d = IDLE;
                end else begin
                    flush_d = 1'b1;
                    state_d = WR_CMD;
                end
            end
            WR_CMD: begin
                if (cmd_fire) begin
                    addr_d  = addr_q + {21'd0, burst_q, 2'b00};
                    burst_d = 7'd0;
                    state_d = (flush_q || (words_q == 31'd0)) ? IDLE : WR_FILL;
                end
            end
            RD_CMD: begin
                if (!di_read_mode) begin
                    state_d = IDLE;
                end else if (cmd_fire) begin
                    out_cnt_d = rd_n;
                    addr_d    = addr_q + {21'd0, rd_n, 2'b00};
                    words_d   = words_q - {24'd0, rd_n};
                    half_d    = 1'b0;
                    state_d   = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (rd_rdy && di_read) begin
                    if (!half_q && !rd_last_tail) begin
                        half_d = 1'b1;
                    end else begin
                        rd_pop    = 1'b1;
                        half_d    = 1'b0;
                        out_cnt_d = out_cnt_q - 7'd1;
                    end
                end
                if (out_cnt_d == 7'd0)
                    state_d = ((words_q != 31'd0) && di_read_mode) ? RD_CMD : IDLE;
                else if (!di_read_mode)
                    state_d = RD_FLUSH;
            end
            RD_FLUSH: begin
                if (out_cnt_q == 7'd0) begin
                    state_d = IDLE;
                end else if (!p_rd_empty) begin
                    rd_pop    = 1'b1;
                    half_d    = 1'b0;
                    out_cnt_d = out_cnt_q - 7'd1;
                    if (out_cnt_q == 7'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; mode history feeds the start-edge detect.
    always_ff @(posedge ifclk) begin
        if (!resetb) begin
            state_q   <= IDLE;
            addr_q    <= 30'd0;
            words_q   <= 31'd0;
            tail_q    <= 1'b0;
            burst_q   <= 7'd0;
            low_q     <= 16'h0;
            low_vld_q <= 1'b0;
            flush_q   <= 1'b0;
            out_cnt_q <= 7'd0;
            half_q    <= 1'b0;
            status_q  <= 1'b0;
            armed_q   <= 1'b0;
            wmode_q   <= 1'b0;
            rmode_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            tail_q    <= tail_d;
            burst_q   <= burst_d;
            low_q     <= low_d;
            low_vld_q <= low_vld_d;
            flush_q   <= flush_d;
            out_cnt_q <= out_cnt_d;
            half_q    <= half_d;
            status_q  <= status_d;
            armed_q   <= armed_d;
            wmode_q   <= di_write_mode;
            rmode_q   <= di_read_mode;
        end
    end

    assign di_write_rdy       = wr_rdy;
    assign di_read_rdy        = rd_rdy;
    assign di_reg_datao       = (state_q == RD_DRAIN) ?
                                (half_q ? p_rd_data[31:16] : p_rd_data[15:0]) : 16'h0000;
    assign di_transfer_status = {15'd0, status_q};
    assign p_cmd_en           = cmd_en;
    assign p_cmd_instr        = (state_q == RD_CMD) ? 3'b001 : 3'b000;
    assign p_cmd_bl           = (state_q == WR_CMD) ? burst_m1[5:0] :
                                ((state_q == RD_CMD) ? rd_n_m1[5:0] : 6'd0);
    assign p_cmd_byte_addr    = ((state_q == WR_CMD) || (state_q == RD_CMD)) ? addr_q : 30'd0;
    assign p_wr_en            = wr_push;
    assign p_wr_mask          = wr_mask;
    assign p_wr_data          = wr_data;
    assign p_rd_en            = rd_pop;
    assign dbg_state_o        = state_q;

endmodule
